// File: rtl/writeback_skid_stage_if.sv
// Handshake and bundle signals between the memory stage, the writeback skid stage and the commit side.
interface writeback_skid_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RD_W = 5
);
   // memory-stage side
   logic            valid_m_i;
   logic            ready_m_o;
   logic [31:0]     instr_m_i;
   logic [XLEN-1:0] alu_result_m_i;
   logic [XLEN-1:0] reduced_data_m_i;
   logic [XLEN-1:0] pc_target_m_i;
   logic [XLEN-1:0] pc_plus4_m_i;
   logic [XLEN-1:0] imm_ext_m_i;
   logic [XLEN-1:0] csr_data_m_i;
   logic [XLEN-1:0] csr_result_m_i;
   logic [11:0]     csr_addr_m_i;
   logic [RD_W-1:0] rd_m_i;
   logic [2:0]      result_src_m_i;
   logic            reg_write_m_i;
   logic            csr_we_m_i;
   // commit side
   logic            ready_w_i;
   logic            valid_w_o;
   logic [31:0]     instr_w_o;
   logic [XLEN-1:0] result_w_o;
   logic [XLEN-1:0] csr_result_w_o;
   logic [11:0]     csr_addr_w_o;
   logic [RD_W-1:0] rd_w_o;
   logic            reg_write_w_o;
   logic            csr_we_w_o;
   logic            retire_w_o;

   // view of the writeback stage itself
   modport slave (
      input  valid_m_i, instr_m_i, alu_result_m_i, reduced_data_m_i, pc_target_m_i,
             pc_plus4_m_i, imm_ext_m_i, csr_data_m_i, csr_result_m_i, csr_addr_m_i,
             rd_m_i, result_src_m_i, reg_write_m_i, csr_we_m_i, ready_w_i,
      output ready_m_o, valid_w_o, instr_w_o, result_w_o, csr_result_w_o, csr_addr_w_o,
             rd_w_o, reg_write_w_o, csr_we_w_o, retire_w_o
   );

   // view of the surrounding pipeline
   modport master (
      output valid_m_i, instr_m_i, alu_result_m_i, reduced_data_m_i, pc_target_m_i,
             pc_plus4_m_i, imm_ext_m_i, csr_data_m_i, csr_result_m_i, csr_addr_m_i,
             rd_m_i, result_src_m_i, reg_write_m_i, csr_we_m_i, ready_w_i,
      input  ready_m_o, valid_w_o, instr_w_o, result_w_o, csr_result_w_o, csr_addr_w_o,
             rd_w_o, reg_write_w_o, csr_we_w_o, retire_w_o
   );
endinterface

// File: rtl/writeback_skid_stage.sv
// Writeback stage with a two-entry skid buffer, rd==0 write suppression, flush and instret counter.
module writeback_skid_stage #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned CNT_WIDTH = 64,
   parameter int unsigned RD_W      = 5
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   writeback_skid_stage_if.slave wb,
   input  logic                 flush_i,
   input  logic                 instret_inhibit_i,
   input  logic                 instret_we_i,
   input  logic [CNT_WIDTH-1:0] instret_wdata_i,
   output logic [CNT_WIDTH-1:0] instret_o
);
   // result-select encodings shared with the control unit
   localparam logic [2:0] RESULT_ALU      = 3'b000;
   localparam logic [2:0] RESULT_MEM_DATA = 3'b001;
   localparam logic [2:0] RESULT_PCPLUS4  = 3'b010;
   localparam logic [2:0] RESULT_IMM_EXT  = 3'b011;
   localparam logic [2:0] RESULT_PCTARGET = 3'b100;
   localparam logic [2:0] RESULT_CSR      = 3'b101;

   // state encoding is {skid_valid, main_valid}
   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] ONE   = 2'b01;
   localparam logic [1:0] FULL  = 2'b11;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] mem;
      logic [XLEN-1:0] pct;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] csr_data;
      logic [XLEN-1:0] csr_result;
      logic [11:0]     csr_addr;
      logic [RD_W-1:0] rd;
      logic [2:0]      src;
      logic            reg_write;
      logic            csr_we;
   } bundle_t;

   logic [1:0]           state_q, state_d;
   bundle_t              main_q, main_d;
   bundle_t              skid_q, skid_d;
   bundle_t              in_b;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;
   logic                 accept;
   logic                 fire;
   logic                 ready_m;
   logic                 main_valid;
   logic [XLEN-1:0]      result_mux;

   assign main_valid = state_q[0];
   assign ready_m    = ~state_q[1];
   assign accept     = wb.valid_m_i & ready_m;
   assign fire       = main_valid & wb.ready_w_i;

   // gather the incoming entry into one bundle
   always_comb begin
      in_b            = '0;
      in_b.instr      = wb.instr_m_i;
      in_b.alu        = wb.alu_result_m_i;
      in_b.mem        = wb.reduced_data_m_i;
      in_b.pct        = wb.pc_target_m_i;
      in_b.pc4        = wb.pc_plus4_m_i;
      in_b.imm        = wb.imm_ext_m_i;
      in_b.csr_data   = wb.csr_data_m_i;
      in_b.csr_result = wb.csr_result_m_i;
      in_b.csr_addr   = wb.csr_addr_m_i;
      in_b.rd         = wb.rd_m_i;
      in_b.src        = wb.result_src_m_i;
      in_b.reg_write  = wb.reg_write_m_i;
      in_b.csr_we     = wb.csr_we_m_i;
   end

   // skid-buffer next state; flush empties both slots but never blocks a retire
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = in_b;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && fire) begin
               main_d = in_b;
            end else if (accept) begin
               skid_d  = in_b;
               state_d = FULL;
            end else if (fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (fire) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) state_d = EMPTY;
   end

   // retired-instruction counter: CSR write wins over increment
   always_comb begin
      instret_d = instret_q;
      if (instret_we_i) instret_d = instret_wdata_i;
      else if (fire && !instret_inhibit_i) instret_d = instret_q + CNT_WIDTH'(1);
   end

   // state, bundles and counter registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         instret_q <= instret_d;
      end
   end

   // result select off the head entry
   always_comb begin
      result_mux = '0;
      case (main_q.src)
         RESULT_ALU:      result_mux = main_q.alu;
         RESULT_MEM_DATA: result_mux = main_q.mem;
         RESULT_PCPLUS4:  result_mux = main_q.pc4;
         RESULT_IMM_EXT:  result_mux = main_q.imm;
         RESULT_PCTARGET: result_mux = main_q.pct;
         RESULT_CSR:      result_mux = main_q.csr_data;
         default:         result_mux = '0;
      endcase
   end

   assign wb.ready_m_o      = ready_m;
   assign wb.valid_w_o      = main_valid;
   assign wb.instr_w_o      = main_q.instr;
   assign wb.result_w_o     = result_mux;
   assign wb.csr_result_w_o = main_q.csr_result;
   assign wb.csr_addr_w_o   = main_q.csr_addr;
   assign wb.rd_w_o         = main_q.rd;
   assign wb.reg_write_w_o  = fire & main_q.reg_write & (main_q.rd != '0);
   assign wb.csr_we_w_o     = fire & main_q.csr_we;
   assign wb.retire_w_o     = fire;
   assign instret_o         = instret_q;
endmodule

// File: tb/tb_writeback_skid_stage.sv
// Self-checking bench for writeback_skid_stage: queue-based reference model, vector table and corner sequences.
module tb_writeback_skid_stage;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned CNT_WIDTH = 64;
   localparam int unsigned RD_W      = 5;

   localparam logic [2:0] R_ALU = 3'b000, R_MEM = 3'b001, R_PC4 = 3'b010,
                          R_IMM = 3'b011, R_PCT = 3'b100, R_CSR = 3'b101;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] alu, mem, pct, pc4, imm, csrd, csrr;
      logic [11:0] caddr;
      logic [4:0]  rd;
      logic [2:0]  src;
      logic        rw, cwe;
   } ent_t;

   typedef struct packed {
      logic [2:0]  src;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] exp_res;
      logic        exp_rw;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 flush, inh, iwe;
   logic [CNT_WIDTH-1:0] iwdata;
   logic [CNT_WIDTH-1:0] instret;

   int   n_checks = 0;
   int   n_pass   = 0;
   ent_t q[$];
   logic [63:0] m_cnt;

   always #5 clk = ~clk;

   writeback_skid_stage_if #(.XLEN(XLEN), .RD_W(RD_W)) bus();

   writeback_skid_stage #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH), .RD_W(RD_W)) dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .wb                (bus),
      .flush_i           (flush),
      .instret_inhibit_i (inh),
      .instret_we_i      (iwe),
      .instret_wdata_i   (iwdata),
      .instret_o         (instret)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] sel(input ent_t e);
      case (e.src)
         R_ALU:   return e.alu;
         R_MEM:   return e.mem;
         R_PC4:   return e.pc4;
         R_IMM:   return e.imm;
         R_PCT:   return e.pct;
         R_CSR:   return e.csrd;
         default: return 32'h0;
      endcase
   endfunction

   function automatic ent_t mk(input logic [31:0] tag);
      ent_t e;
      e       = '0;
      e.instr = 32'h1000_0000 | tag;
      e.alu   = tag;
      e.rd    = 5'd1;
      e.rw    = 1'b1;
      e.src   = R_ALU;
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      ent_t e;
      e.instr = $urandom; e.alu = $urandom; e.mem = $urandom; e.pct = $urandom;
      e.pc4 = $urandom; e.imm = $urandom; e.csrd = $urandom; e.csrr = $urandom;
      e.caddr = 12'($urandom);
      e.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      e.src   = 3'($urandom);
      e.rw    = 1'($urandom);
      e.cwe   = 1'($urandom);
      return e;
   endfunction

   // one clock: drive, compare against the queue model, then advance the model
   task automatic step(input ent_t e, input bit v, input bit rdy, input bit fl, input bit rst,
                       input bit ih, input bit we, input logic [63:0] wd);
      ent_t h;
      bit   ev, fire, acc;
      @(negedge clk);
      reset = rst; flush = fl; inh = ih; iwe = we; iwdata = wd;
      bus.valid_m_i = v; bus.ready_w_i = rdy;
      bus.instr_m_i = e.instr; bus.alu_result_m_i = e.alu; bus.reduced_data_m_i = e.mem;
      bus.pc_target_m_i = e.pct; bus.pc_plus4_m_i = e.pc4; bus.imm_ext_m_i = e.imm;
      bus.csr_data_m_i = e.csrd; bus.csr_result_m_i = e.csrr; bus.csr_addr_m_i = e.caddr;
      bus.rd_m_i = e.rd; bus.result_src_m_i = e.src; bus.reg_write_m_i = e.rw;
      bus.csr_we_m_i = e.cwe;
      #1;
      ev = (q.size() > 0);
      h  = ev ? q[0] : '0;
      chk("ready_m", 64'(bus.ready_m_o), 64'(q.size() < 2));
      chk("valid_w", 64'(bus.valid_w_o), 64'(ev));
      if (ev) begin
         chk("instr_w", 64'(bus.instr_w_o), 64'(h.instr));
         chk("result_w", 64'(bus.result_w_o), 64'(sel(h)));
         chk("csr_result_w", 64'(bus.csr_result_w_o), 64'(h.csrr));
         chk("csr_addr_w", 64'(bus.csr_addr_w_o), 64'(h.caddr));
         chk("rd_w", 64'(bus.rd_w_o), 64'(h.rd));
      end
      fire = ev && rdy;
      acc  = v && (q.size() < 2);
      chk("reg_write_w", 64'(bus.reg_write_w_o), 64'(fire && h.rw && (h.rd != 5'd0)));
      chk("csr_we_w", 64'(bus.csr_we_w_o), 64'(fire && h.cwe));
      chk("retire_w", 64'(bus.retire_w_o), 64'(fire));
      chk("instret", instret, m_cnt);
      if (rst) begin
         q.delete();
         m_cnt = '0;
      end else begin
         if (we) m_cnt = wd;
         else if (fire && !ih) m_cnt = m_cnt + 64'd1;
         if (fl) q.delete();
         else begin
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(e);
         end
      end
   endtask

   task automatic go(input ent_t e, input bit v, input bit rdy);
      step(e, v, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
   endtask

   vec_t vt[9];
   ent_t z, a, b, c;
   logic [63:0] cnt_before;

   initial begin
      z = '0;
      vt[0] = '{src: R_ALU, rd: 5'd5, rw: 1'b1, exp_res: 32'h11, exp_rw: 1'b1};
      vt[1] = '{src: R_PCT, rd: 5'd6, rw: 1'b1, exp_res: 32'h22, exp_rw: 1'b1};
      vt[2] = '{src: R_PC4, rd: 5'd7, rw: 1'b1, exp_res: 32'h33, exp_rw: 1'b1};
      vt[3] = '{src: R_IMM, rd: 5'd8, rw: 1'b1, exp_res: 32'h44, exp_rw: 1'b1};
      vt[4] = '{src: R_MEM, rd: 5'd9, rw: 1'b1, exp_res: 32'h55, exp_rw: 1'b1};
      vt[5] = '{src: R_CSR, rd: 5'd10, rw: 1'b0, exp_res: 32'h66, exp_rw: 1'b0};
      vt[6] = '{src: 3'b111, rd: 5'd11, rw: 1'b1, exp_res: 32'h0, exp_rw: 1'b1};
      vt[7] = '{src: 3'b110, rd: 5'd12, rw: 1'b1, exp_res: 32'h0, exp_rw: 1'b1};
      vt[8] = '{src: R_ALU, rd: 5'd0, rw: 1'b1, exp_res: 32'h11, exp_rw: 1'b0};

      // initial reset without checks (state unknown before it)
      reset = 1'b1; flush = 1'b0; inh = 1'b0; iwe = 1'b0; iwdata = '0;
      bus.valid_m_i = 1'b0; bus.ready_w_i = 1'b0;
      repeat (2) @(posedge clk);
      q.delete(); m_cnt = '0;
      go(z, 1'b0, 1'b0);
      chk("reset_ready_m", 64'(bus.ready_m_o), 64'd1);
      chk("reset_valid_w", 64'(bus.valid_w_o), 64'd0);
      chk("reset_result_w", 64'(bus.result_w_o), 64'd0);

      // streaming: 10 back-to-back ALU results
      for (int i = 1; i <= 10; i++) begin
         go(mk(32'(i)), 1'b1, 1'b1);
         chk("stream_ready_m", 64'(bus.ready_m_o), 64'd1);
         if (i >= 2) chk("stream_result", 64'(bus.result_w_o), 64'(i - 1));
      end
      go(z, 1'b0, 1'b1);
      chk("stream_result_last", 64'(bus.result_w_o), 64'd10);
      go(z, 1'b0, 1'b0);
      chk("stream_instret", instret, 64'd10);
      chk("stream_empty", 64'(bus.valid_w_o), 64'd0);

      // backpressure: A, B fill the buffer, C waits upstream
      a = mk(32'hA); b = mk(32'hB); c = mk(32'hC);
      go(a, 1'b1, 1'b0);
      go(b, 1'b1, 1'b0);
      chk("bp_head_a", 64'(bus.instr_w_o), 64'(a.instr));
      go(c, 1'b1, 1'b0);
      chk("bp_ready_low", 64'(bus.ready_m_o), 64'd0);
      go(c, 1'b1, 1'b1);
      chk("bp_retire_a", 64'(bus.instr_w_o), 64'(a.instr));
      go(c, 1'b1, 1'b1);
      chk("bp_retire_b", 64'(bus.instr_w_o), 64'(b.instr));
      go(z, 1'b0, 1'b1);
      chk("bp_retire_c", 64'(bus.instr_w_o), 64'(c.instr));
      go(z, 1'b0, 1'b1);
      chk("bp_drained", 64'(bus.valid_w_o), 64'd0);

      // result mux and rd==0 vectors
      for (int i = 0; i < 9; i++) begin
         a = '0;
         a.instr = 32'h2000_0000 + 32'(i);
         a.alu = 32'h11; a.pct = 32'h22; a.pc4 = 32'h33; a.imm = 32'h44;
         a.mem = 32'h55; a.csrd = 32'h66;
         a.src = vt[i].src; a.rd = vt[i].rd; a.rw = vt[i].rw;
         go(a, 1'b1, 1'b0);
         go(z, 1'b0, 1'b1);
         chk("vec_result", 64'(bus.result_w_o), 64'(vt[i].exp_res));
         chk("vec_reg_write", 64'(bus.reg_write_w_o), 64'(vt[i].exp_rw));
         chk("vec_retire", 64'(bus.retire_w_o), 64'd1);
      end

      // flush while FULL with a retire and a dropped accept
      go(mk(32'h71), 1'b1, 1'b0);
      go(mk(32'h72), 1'b1, 1'b0);
      cnt_before = instret;
      step(mk(32'h73), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
      chk("flush_retire", 64'(bus.retire_w_o), 64'd1);
      go(z, 1'b0, 1'b0);
      chk("flush_valid_w", 64'(bus.valid_w_o), 64'd0);
      chk("flush_ready_m", 64'(bus.ready_m_o), 64'd1);
      chk("flush_instret", instret, cnt_before + 64'd1);

      // counter: wrap, inhibit, CSR write beating a retire
      step(mk(32'h81), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '1);
      go(z, 1'b0, 1'b1);
      chk("cnt_loaded", instret, '1);
      go(z, 1'b0, 1'b0);
      chk("cnt_wrap", instret, 64'd0);
      go(mk(32'h82), 1'b1, 1'b0);
      step(z, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
      go(z, 1'b0, 1'b0);
      chk("cnt_inhibit", instret, 64'd0);
      go(mk(32'h83), 1'b1, 1'b0);
      step(z, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1234);
      go(z, 1'b0, 1'b0);
      chk("cnt_we_wins", instret, 64'h1234);

      // reset while FULL
      go(mk(32'h91), 1'b1, 1'b0);
      go(mk(32'h92), 1'b1, 1'b0);
      step(z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
      go(z, 1'b0, 1'b1);
      chk("rst_valid_w", 64'(bus.valid_w_o), 64'd0);
      chk("rst_ready_m", 64'(bus.ready_m_o), 64'd1);
      chk("rst_instret", instret, 64'd0);
      chk("rst_reg_write", 64'(bus.reg_write_w_o), 64'd0);
      chk("rst_csr_we", 64'(bus.csr_we_w_o), 64'd0);
      chk("rst_retire", 64'(bus.retire_w_o), 64'd0);
      chk("rst_result", 64'(bus.result_w_o), 64'd0);

      // randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         step(rnd_ent(), 1'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              {32'($urandom), 32'($urandom)});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
